// File: rtl/tc_period_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tc_period_meter_if
//  Description : Signal bundle between a terminal-count source and the
//                period meter. The source drives clear/tc. The meter drives
//                the measurement results and status flags back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tc_period_meter_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             tc;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] reload_est;
  logic             period_valid;
  logic             locked;
  logic             mismatch;
  logic             overflow;

  // Source side: owns the pulse stream and the synchronous clear
  modport master (
    output clear,
    output tc,
    input  period,
    input  reload_est,
    input  period_valid,
    input  locked,
    input  mismatch,
    input  overflow
  );

  // Meter side: consumes tc, reports what it measured
  modport slave (
    input  clear,
    input  tc,
    output period,
    output reload_est,
    output period_valid,
    output locked,
    output mismatch,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/tc_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tc_period_meter
//  Description : Recovers the reload value of a free-running reload counter
//                by timing the gap between rising edges of its terminal-count
//                pulse. Each new gap is compared with the previous one. After
//                LOCK_COUNT consecutive equal gaps the meter reports lock. A
//                gap that runs past the counter range sets a sticky overflow
//                flag and drops the meter back to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_period_meter #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  tc_period_meter_if.slave    bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The match counter must be able to hold LOCK_COUNT itself.
  localparam int c_match_w = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH-1:0]     c_gap_max   = '1;
  localparam logic [WIDTH-1:0]     c_gap_one   = WIDTH'(1);
  localparam logic [c_match_w-1:0] c_lock_cnt  = c_match_w'(LOCK_COUNT);
  localparam logic [c_match_w-1:0] c_match_one = c_match_w'(1);

  // --------------------------------------------------------------------------
  // State encoding
  //   S_IDLE    : no reference rise yet. The next rise only starts timing.
  //   S_MEASURE : timing gaps while the lock criterion is not yet met.
  //   S_LOCKED  : the last LOCK_COUNT comparisons all matched.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_tc_d;
  logic [WIDTH-1:0]       r_gap_cnt;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       r_reload_est;
  logic                   r_period_valid;
  logic                   r_mismatch;
  logic                   r_overflow;
  logic [c_match_w-1:0]   r_match_cnt;
  // A comparison is only meaningful once a measurement exists in this run.
  // r_period alone cannot signal this, because it survives an overflow.
  logic                   r_have_prev;

  logic                   w_rise;
  logic                   w_counting;
  logic                   w_measure;
  logic                   w_saturate;
  logic                   w_same;
  logic                   w_break;
  logic [c_match_w-1:0]   w_match_nxt;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  // A tc level held high for many cycles is one event. Only its rising
  // edge is used.
  assign w_rise     = bus.tc & ~r_tc_d;
  assign w_counting = (r_state != S_IDLE);

  // A rise while timing closes the current gap and produces a measurement.
  assign w_measure  = w_counting & w_rise;

  // The gap counter is already at full scale and no rise arrived. The next
  // count cannot be represented, so the measurement is abandoned. A rise on
  // that same cycle is still a valid full-scale measurement.
  assign w_saturate = w_counting & ~w_rise & (r_gap_cnt == c_gap_max);

  // The current gap equals the previous measurement.
  assign w_same     = r_have_prev & (r_gap_cnt == r_period);

  // A locked meter sees a different gap. This measurement breaks lock.
  assign w_break    = (r_state == S_LOCKED) & w_measure & ~w_same;

  // Consecutive-match counter update. It saturates at the lock threshold.
  always_comb begin
    w_match_nxt = '0;
    if (w_same) begin
      if (r_match_cnt >= c_lock_cnt) begin
        w_match_nxt = c_lock_cnt;
      end else begin
        w_match_nxt = r_match_cnt + c_match_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register. clear takes priority over any event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (bus.clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic driven by rise, saturation and match events
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (w_saturate) begin
          w_state_nxt = S_IDLE;
        end else if (w_measure && (w_match_nxt == c_lock_cnt)) begin
          w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_saturate) begin
          w_state_nxt = S_IDLE;
        end else if (w_break) begin
          w_state_nxt = S_MEASURE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Edge detector, gap counter, measurement registers and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tc_d         <= 1'b0;
      r_gap_cnt      <= '0;
      r_period       <= '0;
      r_reload_est   <= '0;
      r_period_valid <= 1'b0;
      r_mismatch     <= 1'b0;
      r_overflow     <= 1'b0;
      r_match_cnt    <= '0;
      r_have_prev    <= 1'b0;
    end else if (bus.clear) begin
      r_tc_d         <= 1'b0;
      r_gap_cnt      <= '0;
      r_period       <= '0;
      r_reload_est   <= '0;
      r_period_valid <= 1'b0;
      r_mismatch     <= 1'b0;
      r_overflow     <= 1'b0;
      r_match_cnt    <= '0;
      r_have_prev    <= 1'b0;
    end else begin
      r_tc_d         <= bus.tc;
      // Both pulses are registered, so each lasts exactly the cycle that
      // follows the triggering edge.
      r_period_valid <= w_measure;
      r_mismatch     <= w_break;

      if (!w_counting) begin
        // The first rise only opens the timing window.
        if (w_rise) begin
          r_gap_cnt <= c_gap_one;
        end
      end else if (w_measure) begin
        r_period     <= r_gap_cnt;
        r_reload_est <= r_gap_cnt - c_gap_one;
        r_match_cnt  <= w_match_nxt;
        r_have_prev  <= 1'b1;
        // The rising edge itself is cycle 1 of the next gap.
        r_gap_cnt    <= c_gap_one;
      end else if (w_saturate) begin
        // Keep the last good period. Forget it as a comparison reference.
        r_overflow  <= 1'b1;
        r_match_cnt <= '0;
        r_have_prev <= 1'b0;
        r_gap_cnt   <= '0;
      end else begin
        r_gap_cnt <= r_gap_cnt + c_gap_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.period       = r_period;
  assign bus.reload_est   = r_reload_est;
  assign bus.period_valid = r_period_valid;
  assign bus.locked       = (r_state == S_LOCKED);
  assign bus.mismatch     = r_mismatch;
  assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tc_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tc_period_meter
//  Description : Directed testbench for tc_period_meter (WIDTH=8,
//                LOCK_COUNT=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_period_meter;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  int   cyc;
  int   last_rise;

  tc_period_meter_if #(.WIDTH(8)) m_if ();

  tc_period_meter #(
    .WIDTH      (8),
    .LOCK_COUNT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse tc for one cycle so that its rise lands n edges after the previous rise
  task automatic rise_after(input int n);
    m_if.tc = 1'b0;
    while (cyc - last_rise < n - 1) tick();
    m_if.tc = 1'b1;
    tick();
    m_if.tc = 1'b0;
    last_rise = cyc;
  endtask

  // Synchronous clear pulse
  task automatic do_clear();
    m_if.clear = 1'b1;
    tick();
    m_if.clear = 1'b0;
    last_rise = cyc;
  endtask

  // Reach lock at 21: four rises, then lock asserts on the fourth
  task automatic lock_at_21(input string tag);
    rise_after(2);
    rise_after(21);
    rise_after(21);
    total++; if (m_if.locked !== 1'b0) $display("FAIL %s_lock3: got %0b want 0", tag, m_if.locked); else passed++;
    rise_after(21);
    total++; if (m_if.locked !== 1'b1) $display("FAIL %s_lock4: got %0b want 1", tag, m_if.locked); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_if.clear = 1'b0;
    m_if.tc = 1'b0;
    repeat (3) tick();
    total++; if ({m_if.period, m_if.reload_est} !== 16'h0000) $display("FAIL reset_period: got %0d/%0d want 0/0", m_if.period, m_if.reload_est); else passed++;
    total++; if ({m_if.period_valid, m_if.locked, m_if.mismatch, m_if.overflow} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {m_if.period_valid, m_if.locked, m_if.mismatch, m_if.overflow}); else passed++;
    reset = 1'b1;
    tick();
    last_rise = cyc;
  endtask

  task automatic test_lock();
    rise_after(2);
    total++; if (m_if.period_valid !== 1'b0) $display("FAIL lock_first_rise_valid: got %0b want 0", m_if.period_valid); else passed++;
    rise_after(21);
    total++; if (m_if.period_valid !== 1'b1) $display("FAIL lock_valid: got %0b want 1", m_if.period_valid); else passed++;
    total++; if (m_if.period !== 8'd21) $display("FAIL lock_period: got %0d want 21", m_if.period); else passed++;
    total++; if (m_if.reload_est !== 8'd20) $display("FAIL lock_reload: got %0d want 20", m_if.reload_est); else passed++;
    tick();
    total++; if (m_if.period_valid !== 1'b0) $display("FAIL lock_valid_width: got %0b want 0", m_if.period_valid); else passed++;
    rise_after(21);
    total++; if (m_if.locked !== 1'b0) $display("FAIL lock_after3: got %0b want 0", m_if.locked); else passed++;
    rise_after(21);
    total++; if (m_if.locked !== 1'b1) $display("FAIL lock_after4: got %0b want 1", m_if.locked); else passed++;
  endtask

  task automatic test_mismatch();
    rise_after(31);
    total++; if (m_if.period !== 8'd31 || m_if.reload_est !== 8'd30) $display("FAIL mm_period: got %0d/%0d want 31/30", m_if.period, m_if.reload_est); else passed++;
    total++; if (m_if.mismatch !== 1'b1 || m_if.locked !== 1'b0 || m_if.period_valid !== 1'b1) $display("FAIL mm_flags: got mm=%0b lk=%0b pv=%0b want 1/0/1", m_if.mismatch, m_if.locked, m_if.period_valid); else passed++;
    tick();
    total++; if (m_if.mismatch !== 1'b0) $display("FAIL mm_pulse_width: got %0b want 0", m_if.mismatch); else passed++;
    rise_after(31);
    total++; if (m_if.locked !== 1'b0 || m_if.mismatch !== 1'b0) $display("FAIL mm_relock1: got lk=%0b mm=%0b want 0/0", m_if.locked, m_if.mismatch); else passed++;
    rise_after(31);
    total++; if (m_if.locked !== 1'b1) $display("FAIL mm_relock2: got %0b want 1", m_if.locked); else passed++;
  endtask

  task automatic test_held_high();
    do_clear();
    for (int k = 1; k <= 4; k++) begin
      m_if.tc = 1'b0;
      while (cyc - last_rise < 20) tick();
      m_if.tc = 1'b1;
      tick();
      last_rise = cyc;
      if (k == 2) begin
        total++; if (m_if.period_valid !== 1'b1 || m_if.period !== 8'd21) $display("FAIL held_period: got pv=%0b p=%0d want 1/21", m_if.period_valid, m_if.period); else passed++;
      end
      repeat (9) tick();
      if (k == 2) begin
        total++; if (m_if.period_valid !== 1'b0 || m_if.period !== 8'd21) $display("FAIL held_once: got pv=%0b p=%0d want 0/21", m_if.period_valid, m_if.period); else passed++;
      end
      if (k == 4) begin
        total++; if (m_if.locked !== 1'b1) $display("FAIL held_locked: got %0b want 1", m_if.locked); else passed++;
      end
      m_if.tc = 1'b0;
    end
  endtask

  task automatic test_overflow();
    do_clear();
    lock_at_21("ovf");
    repeat (254) tick();
    total++; if (m_if.overflow !== 1'b0 || m_if.locked !== 1'b1) $display("FAIL ovf_before: got ov=%0b lk=%0b want 0/1", m_if.overflow, m_if.locked); else passed++;
    tick();
    total++; if (m_if.overflow !== 1'b1 || m_if.locked !== 1'b0) $display("FAIL ovf_set: got ov=%0b lk=%0b want 1/0", m_if.overflow, m_if.locked); else passed++;
    total++; if (m_if.period !== 8'd21 || m_if.period_valid !== 1'b0) $display("FAIL ovf_period_kept: got p=%0d pv=%0b want 21/0", m_if.period, m_if.period_valid); else passed++;
    repeat (45) tick();
    m_if.tc = 1'b1;
    tick();
    m_if.tc = 1'b0;
    last_rise = cyc;
    total++; if (m_if.period_valid !== 1'b0) $display("FAIL ovf_idle_rise: got %0b want 0", m_if.period_valid); else passed++;
    rise_after(21);
    total++; if (m_if.period_valid !== 1'b1 || m_if.period !== 8'd21 || m_if.overflow !== 1'b1) $display("FAIL ovf_resume: got pv=%0b p=%0d ov=%0b want 1/21/1", m_if.period_valid, m_if.period, m_if.overflow); else passed++;
  endtask

  task automatic test_full_scale();
    do_clear();
    total++; if (m_if.overflow !== 1'b0) $display("FAIL clear_overflow: got %0b want 0", m_if.overflow); else passed++;
    rise_after(2);
    rise_after(255);
    total++; if (m_if.period !== 8'd255 || m_if.reload_est !== 8'd254 || m_if.period_valid !== 1'b1) $display("FAIL full_period: got %0d/%0d pv=%0b want 255/254/1", m_if.period, m_if.reload_est, m_if.period_valid); else passed++;
    total++; if (m_if.overflow !== 1'b0) $display("FAIL full_no_ovf: got %0b want 0", m_if.overflow); else passed++;
  endtask

  task automatic test_async_reset_and_clear();
    do_clear();
    lock_at_21("rst");
    repeat (5) tick();
    reset = 1'b0;
    #1;
    total++; if ({m_if.period, m_if.reload_est} !== 16'h0000 || {m_if.period_valid, m_if.locked, m_if.mismatch, m_if.overflow} !== 4'b0000) $display("FAIL async_reset: got p=%0d r=%0d flags=%b want 0/0/0000", m_if.period, m_if.reload_est, {m_if.period_valid, m_if.locked, m_if.mismatch, m_if.overflow}); else passed++;
    #9;
    reset = 1'b1;
    tick();
    last_rise = cyc;
    lock_at_21("rst_relock");
    m_if.clear = 1'b1;
    m_if.tc = 1'b1;
    tick();
    m_if.clear = 1'b0;
    m_if.tc = 1'b0;
    last_rise = cyc;
    total++; if ({m_if.period, m_if.reload_est} !== 16'h0000 || {m_if.period_valid, m_if.locked, m_if.mismatch, m_if.overflow} !== 4'b0000) $display("FAIL sync_clear: got p=%0d r=%0d flags=%b want 0/0/0000", m_if.period, m_if.reload_est, {m_if.period_valid, m_if.locked, m_if.mismatch, m_if.overflow}); else passed++;
    lock_at_21("clr_relock");
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    cyc       = 0;
    last_rise = 0;
    test_reset();
    test_lock();
    test_mismatch();
    test_held_high();
    test_overflow();
    test_full_scale();
    test_async_reset_and_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_period_meter.md
TC_PERIOD_METER -- requirements
Module: tc_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the width of the period counter and outputs.
REQ-002 SHALL have parameter LOCK_COUNT, default 2, meaning the number of consecutive matching measurements required to assert lock.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port clear  input  1  synchronous clear, active-high.
REQ-006 SHALL have port tc  input  1  terminal-count pulse from the reload counter, synchronous to clk.
REQ-007 SHALL have port period  output  WIDTH  last measured cycles between consecutive tc rising edges.
REQ-008 SHALL have port reload_est  output  WIDTH  period minus 1, i.e. the recovered reload value.
REQ-009 SHALL have port period_valid  output  1  one-cycle pulse when period and reload_est update.
REQ-010 SHALL have port locked  output  1  stable period detected.
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse when a measurement breaks lock.
REQ-012 SHALL have port overflow  output  1  sticky flag set when the gap counter saturates.

Function
REQ-013 SHALL register tc into tc_d; rise = tc AND NOT tc_d; only rises are events, so tc held high counts once.
REQ-014 SHALL implement states IDLE (no rise seen), MEASURE (counting, unlocked) and LOCKED.
REQ-015 IDLE: on rise, SHALL go to MEASURE with gap_cnt = 1 and no measurement output.
REQ-016 MEASURE/LOCKED: on a non-rise cycle, SHALL increment gap_cnt by 1.
REQ-017 On rise in MEASURE/LOCKED, SHALL register period = gap_cnt and reload_est = gap_cnt - 1 on that same edge, pulse period_valid high for exactly the following cycle, and reload gap_cnt = 1.
REQ-018 Measured period therefore equals the number of clk edges between the two rises; minimum legal value is 2.
REQ-019 On each measurement, SHALL compare against the previous measurement: if equal, match_cnt increments (saturating at LOCK_COUNT); otherwise match_cnt = 0.
REQ-020 SHALL move MEASURE -> LOCKED and set locked = 1 on the edge where match_cnt reaches LOCK_COUNT.
REQ-021 In LOCKED, a measurement differing from the locked period SHALL clear locked, pulse mismatch for one cycle, set match_cnt = 0, go to MEASURE, and still update period/period_valid.
REQ-022 When gap_cnt would exceed 2^WIDTH-1 without a rise, SHALL set overflow (sticky), clear locked, clear match_cnt, and go to IDLE; period keeps its last value and period_valid does not pulse.
REQ-023 A rise on the same cycle gap_cnt reaches 2^WIDTH-1 SHALL be a valid measurement of 2^WIDTH-1 with no overflow.
REQ-024 clear SHALL have priority over every other event and return all state and outputs to reset values on the next edge, including overflow.
REQ-025 A first rise after clear or overflow SHALL be treated as in IDLE (starts timing only).

Reset
REQ-026 While reset = 0, SHALL hold state = IDLE, gap_cnt = 0, match_cnt = 0, tc_d = 0, period = 0, reload_est = 0, period_valid = 0, locked = 0, mismatch = 0, overflow = 0.
REQ-027 Reset assertion mid-measurement SHALL abort it immediately (asynchronously); after release, the first rise restarts from IDLE.

Verification
REQ-028 1-cycle tc pulses every 21 cycles -> 2nd rise gives period = 21, reload_est = 20, period_valid 1-cycle pulse; locked = 1 after the 4th rise.
REQ-029 Locked at 21, then tc spacing changes to 31 -> next measurement period = 31, reload_est = 30, mismatch pulse, locked = 0; locked = 1 again after two further 31-cycle periods.
REQ-030 tc held high for 10 cycles, then low 11 cycles, repeated -> period = 21 (single event per high phase).
REQ-031 One rise, then tc low for 300 cycles (WIDTH = 8) -> overflow = 1 at gap_cnt saturation, state IDLE, locked = 0; the next rise produces no period_valid.
REQ-032 Rises exactly 255 cycles apart -> period = 255, overflow stays 0.
REQ-033 reset driven low for 10 ns while locked at 21 -> all outputs 0 immediately; after release, lock re-acquired on the 4th rise; clear pulse gives the same result synchronously.
